// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and the FSM state encoding for the UART byte transmitter.
//   UART_DATA_W     : payload width (8)
//   UART_IDLE_LEVEL : line level when no frame is on the wire (high)
//   uart_state_e    : 3-bit transmitter state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   UART_DATA_W     = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_done
// in the last cycle of each bit period. Held at 0 while disabled so every
// frame starts phase-aligned to its accept.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous reset, active-low
//   en       : count enable (high while a frame is in progress)
//   bit_done : one-cycle pulse marking the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    bit_done = en && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q + CNT_W'(1);
    if (!en || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Serialises one byte per valid/ready handshake into a UART frame:
// start bit, 8 data bits LSB first, [even parity], stop bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit
// between the last data bit and the stop bit (8E1 instead of 8N1).
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous reset, active-low (aborts any frame in progress)
//   in_data  : byte to transmit, captured on accept
//   in_valid : in_data is valid
//   in_ready : block can accept a byte this cycle (idle only)
//   tx       : registered serial output, idle high
//   busy     : a frame is in progress
// -----------------------------------------------------------------------------
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy
);

  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

  uart_state_e       state_q;
  logic [2:0]        bit_cnt_q;
  logic              tx_q;
  logic              busy_q;
  logic [DATA_W-1:0] sh_q;
  logic              bit_done;
  logic              accept;
  logic              shift_en;

`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  assign in_ready = ~busy_q;
  assign busy     = busy_q;
  assign tx       = tx_q;
  assign accept   = in_valid && in_ready;

  // The register always presents the next bit at sh_q[0]; it shifts each time
  // that bit is moved onto the line (end of START and of every data bit).
  assign shift_en = bit_done && ((state_q == START) || (state_q == DATA));

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q != IDLE),
    .bit_done(bit_done)
  );

  // Payload registers carry no reset: they are always loaded on accept
  // before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_q <= in_data;
    end else if (shift_en) begin
      sh_q <= sh_q >> 1;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (accept) begin
      parity_q <= ^in_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= START;
            tx_q      <= ~UART_IDLE_LEVEL;
            busy_q    <= 1'b1;
            bit_cnt_q <= 3'd0;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= sh_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              tx_q      <= parity_q;
`else
              state_q   <= STOP;
              tx_q      <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= sh_q[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            tx_q    <= UART_IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= UART_IDLE_LEVEL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_byte
// Scoreboard bench for uart_tx_byte with CLKS_PER_BIT=4. Accepted bytes are
// queued by the driver; a line monitor decodes each frame from tx and compares
// it against the queue head. Define UART_TX_PARITY_EN to exercise parity.
// -----------------------------------------------------------------------------
module tb_uart_tx_byte;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int BOUND = 4000;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] sb_q[$];
  int         starts[$];

  uart_tx_byte #(
    .CLKS_PER_BIT(N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one byte; push it to the scoreboard on the cycle it is accepted.
  task automatic send_byte(input logic [7:0] d, input bit hold);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!acc && n < BOUND) begin
      if (in_ready) begin
        acc = 1'b1;
        sb_q.push_back(d);
        @(posedge clk);
        #1;
        chk("start_low", tx, 1'b0);
        chk("busy_set", busy, 1'b1);
        chk("ready_low", in_ready, 1'b0);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!acc) chk("accept_timeout", 0, 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (n < BOUND), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: frames are detected by a low tx while out of reset.
  logic       m_bits[0:10];
  bit         m_shape_ok;
  bit         m_busy_ok;
  bit         m_abort;
  logic [7:0] m_data;
  logic [7:0] m_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        starts.push_back(cyc);
        m_shape_ok = 1'b1;
        m_busy_ok  = 1'b1;
        m_abort    = 1'b0;
        for (int b = 0; b < FB; b++) begin
          for (int s = 0; s < N; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (!rst_n) begin
              m_abort = 1'b1;
              break;
            end
            if (s == 0) m_bits[b] = tx;
            else if (tx !== m_bits[b]) m_shape_ok = 1'b0;
            if (busy !== 1'b1) m_busy_ok = 1'b0;
          end
          if (m_abort) break;
        end
        if (m_abort) begin
          if (sb_q.size() != 0) void'(sb_q.pop_front());
          while (!rst_n) @(negedge clk);
        end else begin
          @(negedge clk);
          chk("end_busy", busy, 1'b0);
          chk("end_tx_idle", tx, 1'b1);
          chk("bit_shape", m_shape_ok, 1'b1);
          chk("busy_frame", m_busy_ok, 1'b1);
          chk("start_bit", m_bits[0], 1'b0);
          chk("stop_bit", m_bits[FB-1], 1'b1);
          for (int i = 0; i < 8; i++) m_data[i] = m_bits[1+i];
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_frame", m_data, 32'hFFFF_FFFF);
          end else begin
            m_exp = sb_q.pop_front();
            chk("data", m_data, m_exp);
`ifdef UART_TX_PARITY_EN
            chk("parity", m_bits[9], ^m_exp);
`endif
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset held with random upstream activity.
    repeat (6) begin
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_tx", tx, 1'b1);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_ready", in_ready, 1'b1);
    end

    // Single byte.
    starts.delete();
    send_byte(8'hA5, 1'b0);
    wait_idle();
    chk("single_count", starts.size(), 1);

    // Back-to-back with valid held high.
    starts.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b0);
    wait_idle();
    chk("b2b_count", starts.size(), 2);
    if (starts.size() >= 2) chk("b2b_gap", starts[1] - starts[0], FB * N + 1);

    // Valid pulse while busy must be ignored.
    starts.delete();
    send_byte(8'h81, 1'b0);
    repeat (15) @(negedge clk);
    chk("ready_while_busy", in_ready, 1'b0);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    repeat (FB * N) @(negedge clk);
    chk("busy_pulse_count", starts.size(), 1);

    // Asynchronous reset during data bit 3.
    send_byte(8'h55, 1'b0);
    repeat (4 * N + 2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("held_rst_tx", tx, 1'b1);
    rst_n = 1'b1;
    starts.delete();
    send_byte(8'h12, 1'b0);
    wait_idle();
    chk("after_rst_count", starts.size(), 1);

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07, 1'b0);
    wait_idle();
    send_byte(8'h03, 1'b0);
    wait_idle();
`endif

    // A few random bytes.
    for (int k = 0; k < 4; k++) begin
      send_byte(8'($urandom), 1'b0);
    end
    wait_idle();
    chk("sb_empty_end", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
